fifo_wptr_full: RTL

// - Write-domain pointer/flag stage of the async FIFO; sits directly upstream of fifo_mem.
// - Owns binary/Gray write pointer, synchronises the Gray read pointer into wrclk, and produces

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_sync_ff.sv | 31 +++
 rtl/fifo_wptr_full.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversions.
// Used by the write-side pointer stage, the read-side pointer stage and fifo_mem.
package fifo_pkg;

    // Default geometry shared by every stage of the FIFO.
    localparam int unsigned FIFO_DEPTH_DEF   = 8;
    localparam int unsigned PTR_WIDTH_DEF    = 3;
    localparam int unsigned AFULL_THRESH_DEF = 6;
    localparam int unsigned SYNC_STAGES_DEF  = 2;

    // Widest pointer the conversion helpers handle; callers zero-extend into
    // this width and size-cast the result back to their pointer width.
    localparam int unsigned CONV_WIDTH = 32;

    // Binary to reflected Gray code.
    function automatic logic [CONV_WIDTH-1:0] bin2gray(input logic [CONV_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extended upper bits contribute nothing, so any narrower width works.
    function automatic logic [CONV_WIDTH-1:0] gray2bin(input logic [CONV_WIDTH-1:0] gray);
        logic [CONV_WIDTH-1:0] bin;
        bin = gray;
        for (int unsigned i = 1; i < CONV_WIDTH; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_ff.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Plain flop chain, no logic between stages; synchronous active-high reset.
module fifo_sync_ff #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the asynchronous value through STAGES flops; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag stage of the async FIFO.
// Owns the binary/Gray write pointer, brings the Gray read pointer into wrclk,
// and produces full, almost-full, fill level and a sticky overflow flag.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int unsigned AFULL_THRESH = AFULL_THRESH_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic                 wrclk,
    input  logic                 wrst,
    input  logic                 wr_en,
    input  logic                 clr_ovf,
    input  logic [PTR_WIDTH:0]   g_rptr_async,
    output logic                 wr_accept,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 fifo_full,
    output logic                 fifo_afull,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
);

    localparam int unsigned PW1 = PTR_WIDTH + 1;

    // Threshold narrowed to pointer width; the range check below guarantees it fits.
    localparam logic [PTR_WIDTH:0] AFULL_LVL = PW1'(AFULL_THRESH);

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH != (32'd1 << PTR_WIDTH)) begin : g_chk_depth
        $fatal(1, "fifo_wptr_full: FIFO_DEPTH must equal 2**PTR_WIDTH");
    end
    if (PTR_WIDTH < 2) begin : g_chk_ptr
        $fatal(1, "fifo_wptr_full: PTR_WIDTH must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $fatal(1, "fifo_wptr_full: SYNC_STAGES must be at least 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : g_chk_afull
        $fatal(1, "fifo_wptr_full: AFULL_THRESH must lie in 1..FIFO_DEPTH");
    end

    logic [PTR_WIDTH:0] g_rptr_sync;
    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] b_next;
    logic [PTR_WIDTH:0] g_next;
    logic [PTR_WIDTH:0] g_rptr_full_cmp;
    logic [PTR_WIDTH:0] level_next;
    logic               full_next;
    logic               afull_next;

    // Read pointer into the write clock domain.
    fifo_sync_ff #(
        .WIDTH  (PW1),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wrclk),
        .rst (wrst),
        .d   (g_rptr_async),
        .q   (g_rptr_sync)
    );

    // A write is only ever accepted while the registered full flag is low.
    assign wr_accept = wr_en & ~fifo_full;

    // Full in Gray space: write pointer one lap ahead means the top two bits
    // of the read pointer are inverted and the rest are equal.
    assign g_rptr_full_cmp = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};

    // Next-state pointers, level and flags, all derived from the synchronised
    // (possibly stale) read pointer so the flags are pessimistic.
    always_comb begin
        b_next      = b_wptr + {{PTR_WIDTH{1'b0}}, wr_accept};
        g_next      = PW1'(bin2gray(CONV_WIDTH'(b_next)));
        b_rptr_sync = PW1'(gray2bin(CONV_WIDTH'(g_rptr_sync)));
        level_next  = b_next - b_rptr_sync;
        full_next   = (g_next == g_rptr_full_cmp);
        afull_next  = (level_next >= AFULL_LVL);
    end

    // Register pointers and flags together so full rises on the filling write.
    always_ff @(posedge wrclk) begin
        if (wrst) begin
            b_wptr     <= '0;
            g_wptr     <= '0;
            wr_level   <= '0;
            fifo_full  <= 1'b0;
            fifo_afull <= 1'b0;
        end else begin
            b_wptr     <= b_next;
            g_wptr     <= g_next;
            wr_level   <= level_next;
            fifo_full  <= full_next;
            fifo_afull <= afull_next;
        end
    end

    // Sticky overflow: a write attempted while full sets it, and setting wins over clearing.
    always_ff @(posedge wrclk) begin
        if (wrst) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
